// File: rtl/rcv_pkg.sv
// -----------------------------------------------------------------------------
// rcv_pkg -- shared definitions for the UART receive controller.
//
// Contents:
//   DATA_BITS             payload bits per frame
//   DEFAULT_CLKS_PER_BIT  default bit period in clk cycles
//   rcv_state_e           receiver FSM state encoding
//   even_parity()         parity bit that makes the total count of ones even
//
// Configuration: RCV_PARITY_EN adds the StParity state.
// -----------------------------------------------------------------------------
package rcv_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStartChk = 3'd1,
        StData     = 3'd2,
`ifdef RCV_PARITY_EN
        StParity   = 3'd3,
`endif
        StStop     = 3'd4,
        StLoad     = 3'd5
    } rcv_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rcv_timer.sv
// -----------------------------------------------------------------------------
// rcv_timer -- bit-period counter for the UART receiver.
//
// Counts clk cycles since the last clear. half_o marks the middle of the start
// bit (CLKS_PER_BIT/2 cycles after clear), full_o marks one full bit period.
//
// Ports:
//   clk     in   system clock
//   n_rst   in   asynchronous active-low reset
//   clr_i   in   restart the count at zero on the next edge
//   half_o  out  half-period strobe
//   full_o  out  full-period strobe
// -----------------------------------------------------------------------------
module rcv_timer #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    output logic half_o,
    output logic full_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count 0 is the first cycle after the clear, so the strobes fire on
    // count N-1, i.e. N cycles after the clearing event.
    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign half_o = (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1));
    assign full_o = (cnt_q == CntW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/rcv_ctrl.sv
// -----------------------------------------------------------------------------
// rcv_ctrl -- UART receive controller (8 data bits, LSB first, 1 stop bit).
//
// Ports:
//   clk            in   system clock, all state on rising edge
//   n_rst          in   asynchronous active-low reset
//   serial_in      in   raw UART line (idle high, asynchronous)
//   fifo_full      in   receive FIFO full flag
//   data_read      in   one-cycle pulse, clears overrun_error
//   w_enable       out  one-cycle FIFO write strobe
//   w_data         out  received byte; holds the last written byte otherwise
//   framing_error  out  last frame had a zero stop bit
//   overrun_error  out  sticky: a good frame was dropped because FIFO was full
//   parity_error   out  last frame failed even parity (0 if parity disabled)
//
// Configuration: define RCV_PARITY_EN to expect one even-parity bit after
// the data bits.
// -----------------------------------------------------------------------------
module rcv_ctrl
    import rcv_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 fifo_full,
    input  logic                 data_read,
    output logic                 w_enable,
    output logic [DATA_BITS-1:0] w_data,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    rcv_state_e           state_q, state_d;
    logic                 sync1_q, rx_q, rx_prev_q;
    logic                 edge_pend_q, edge_pend_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] w_data_q, w_data_d;
    logic                 framing_q, framing_d;
    logic                 overrun_q, overrun_d;
    logic                 set_ovr;
    logic                 tmr_clr, tmr_half, tmr_full;
    logic                 fall, start;
`ifdef RCV_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    rcv_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr_i  (tmr_clr),
        .half_o (tmr_half),
        .full_o (tmr_full)
    );

    assign fall  = rx_prev_q & ~rx_q;
    // A fall seen while busy finishing a frame is remembered so IDLE can act
    // on it; the line is already low by then, so no new edge would appear.
    assign start = fall | edge_pend_q;

    always_comb begin
        state_d     = state_q;
        edge_pend_d = edge_pend_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        w_data_d    = w_data_q;
        framing_d   = framing_q;
        set_ovr     = 1'b0;
        tmr_clr     = 1'b0;
        w_enable    = 1'b0;
`ifdef RCV_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            StIdle: begin
                tmr_clr     = 1'b1;
                edge_pend_d = 1'b0;
                if (start) begin
                    state_d   = StStartChk;
                    framing_d = 1'b0;
`ifdef RCV_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            StStartChk: begin
                if (tmr_half) begin
                    tmr_clr = 1'b1;
                    // Line back high at mid start bit: a glitch, drop silently.
                    state_d = rx_q ? StIdle : StData;
                end
            end
            StData: begin
                if (tmr_full) begin
                    tmr_clr   = 1'b1;
                    shift_d   = {rx_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef RCV_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef RCV_PARITY_EN
            StParity: begin
                if (tmr_full) begin
                    tmr_clr = 1'b1;
                    if (rx_q != even_parity(shift_q)) begin
                        parity_d = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d  = StStop;
                    end
                end
            end
`endif
            StStop: begin
                if (fall) edge_pend_d = 1'b1;
                if (tmr_full) begin
                    tmr_clr = 1'b1;
                    if (rx_q) begin
                        state_d = StLoad;
                    end else begin
                        framing_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StLoad: begin
                tmr_clr = 1'b1;
                if (fall) edge_pend_d = 1'b1;
                if (fifo_full) begin
                    set_ovr = 1'b1;
                end else begin
                    w_enable = 1'b1;
                    w_data_d = shift_q;
                end
                state_d = StIdle;
            end
            default: begin
                tmr_clr = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    // Set wins over a coincident data_read.
    assign overrun_d = set_ovr | (overrun_q & ~data_read);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            rx_q        <= 1'b1;
            rx_prev_q   <= 1'b1;
            edge_pend_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            w_data_q    <= '0;
            framing_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= serial_in;
            rx_q        <= sync1_q;
            rx_prev_q   <= rx_q;
            edge_pend_q <= edge_pend_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            w_data_q    <= w_data_d;
            framing_q   <= framing_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef RCV_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
    assign parity_error = parity_q;
`else
    assign parity_error = 1'b0;
`endif

    // The write strobe is combinational in LOAD, so present the new byte
    // in that same cycle and the held byte otherwise.
    assign w_data        = w_enable ? shift_q : w_data_q;
    assign framing_error = framing_q;
    assign overrun_error = overrun_q;

endmodule

// File: doc/rcv_ctrl.md
RCV_CTRL -- requirements
Module: rcv_ctrl

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 10, clock cycles per serial bit period (>=4, even).
REQ-002 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: n_rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: serial_in  in  1  raw UART line, idle high, asynchronous to clk.
REQ-005 SHALL have port: fifo_full  in  1  full flag from the receive FIFO.
REQ-006 SHALL have port: data_read  in  1  one-cycle pulse, clears overrun_error.
REQ-007 SHALL have port: w_enable  out  1  one-cycle write strobe to the receive FIFO.
REQ-008 SHALL have port: w_data  out  8  received byte, valid while w_enable=1.
REQ-009 SHALL have port: framing_error  out  1  last frame had stop bit = 0.
REQ-010 SHALL have port: overrun_error  out  1  a good frame was dropped because fifo_full=1.
REQ-011 SHALL have port: parity_error  out  1  last frame failed parity; constant 0 when parity is compiled out.

Function
REQ-012 SHALL pass serial_in through a 2-flop synchronizer; start edge = synced value 1 -> 0.
REQ-013 SHALL implement states IDLE, START_CHK, DATA, PARITY, STOP, LOAD; PARITY is reachable only when PARITY_EN is defined.
REQ-014 IDLE -> START_CHK on start edge; framing_error and parity_error clear on the same edge.
REQ-015 START_CHK SHALL sample at CLKS_PER_BIT/2 cycles after the edge: 0 -> DATA, 1 -> IDLE (glitch, no flags).
REQ-016 DATA SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; a 3-bit bit counter wraps 7 -> 0 on the exit transition.
REQ-017 After the 8th bit SHALL go to PARITY if enabled, else STOP.
REQ-018 STOP SHALL sample one bit period later: 1 -> LOAD; 0 -> set framing_error and go to IDLE with no write.
REQ-019 LOAD (1 cycle): fifo_full=0 -> w_enable=1, w_data=byte; fifo_full=1 -> set overrun_error with no write; then IDLE.
REQ-020 Latency: w_enable SHALL assert exactly 1 cycle after the stop-bit sample cycle.
REQ-021 w_data SHALL hold the last loaded byte between writes; w_enable SHALL be 0 in every state except LOAD.
REQ-022 overrun_error SHALL be sticky until data_read=1; if set and clear coincide, set wins.
REQ-023 A start edge arriving in LOAD or STOP SHALL NOT be lost; detection SHALL resume in IDLE on the next cycle.

Reset
REQ-024 On n_rst=0: state=IDLE, synchronizer flops=1, timer=0, bit counter=0, w_data=8'h00, w_enable=0, all error outputs 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no write and no error flag.

Configuration
REQ-026 Macro RCV_PARITY_EN: when defined, one even-parity bit is sampled after bit 7; a mismatch sets parity_error, the frame is not written, and the state returns to IDLE.
REQ-027 When RCV_PARITY_EN is undefined: no PARITY state, 10-bit frame, parity_error tied to 0.

Structure
REQ-028 Package rcv_pkg SHALL hold the state enum typedef, DATA_BITS=8 and the default CLKS_PER_BIT.
REQ-029 Sub-module rcv_timer (parameterized bit-period counter with half-period and full-period strobes) SHALL be instantiated once.

Verification (CLKS_PER_BIT=10)
REQ-030 Frame 0xA5 with stop=1 and fifo_full=0 -> single w_enable pulse, w_data=8'hA5, 96 cycles after the synced falling edge, no errors.
REQ-031 Frame 0x3C with stop=0 -> no w_enable, framing_error=1 until the next start edge.
REQ-032 Frame 0xFF with fifo_full=1 -> no w_enable, overrun_error=1 held until the data_read pulse; set and data_read in the same cycle -> stays 1.
REQ-033 serial_in low for 3 cycles then high -> return to IDLE, no write, no flags.
REQ-034 n_rst pulsed during bit 4 -> all outputs at reset values; a following frame 0x5A is received correctly.
REQ-035 With RCV_PARITY_EN: 0x01 with parity bit 0 -> parity_error=1, no write; 0x01 with parity bit 1 -> written.
